// File: rtl/windowed_max_pool.sv
// windowed_max_pool: streaming signed max-pool over windows of WINDOW samples (or closed early by in_last), emitting max/argmax/count.
module windowed_max_pool #(
  parameter int WIDTH = 8,
  parameter int WINDOW = 4,
  localparam int IDX_W = (WINDOW > 1) ? $clog2(WINDOW) : 1,
  localparam int CNT_W = $clog2(WINDOW + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_max,
  output logic [IDX_W-1:0] out_idx,
  output logic [CNT_W-1:0] out_count
);
  logic [WIDTH-1:0] acc_max, nmax;
  logic [IDX_W-1:0] acc_idx, nidx;
  logic [CNT_W-1:0] cnt, ncnt;
  logic             acc, first, gt, close;
  assign in_ready = !out_valid || out_ready;
  always_comb begin
    acc   = in_valid && in_ready;
    first = cnt == '0;
    gt    = $signed(in_data) > $signed(acc_max);
    nmax  = (first || gt) ? in_data : acc_max;
    nidx  = first ? '0 : gt ? IDX_W'(cnt) : acc_idx;
    ncnt  = cnt + CNT_W'(1);
    close = (cnt == CNT_W'(WINDOW - 1)) || in_last;
  end
  // A close in the same cycle as a transfer-out reloads the output register, so out_valid stays high.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_max   <= '0;
      acc_idx   <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_max   <= '0;
      out_idx   <= '0;
      out_count <= '0;
    end else begin
      if (acc) begin
        acc_max <= nmax;
        acc_idx <= nidx;
        cnt     <= close ? '0 : ncnt;
        if (close) begin
          out_max   <= nmax;
          out_idx   <= nidx;
          out_count <= ncnt;
        end
      end
      out_valid <= (acc && close) ? 1'b1 : out_ready ? 1'b0 : out_valid;
    end
  end
endmodule

// File: tb/tb_windowed_max_pool.sv
// tb_windowed_max_pool: directed vector table, backpressure/reset sequences and randomized run against a window-list model.
module tb_windowed_max_pool;
  localparam int WIDTH = 8;
  localparam int WINDOW = 4;
  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, in_ready, in_last = 1'b0, out_valid, out_ready = 1'b1;
  logic [WIDTH-1:0] in_data = '0, out_max;
  logic [1:0] out_idx;
  logic [2:0] out_count;
  int n = 0, errs = 0;

  windowed_max_pool #(.WIDTH(WIDTH), .WINDOW(WINDOW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_max(out_max),
    .out_idx(out_idx), .out_count(out_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic v;
    logic l;
    int   d;
    logic ev;
    int   em;
    int   ei;
    int   ec;
  } vec_t;
  vec_t vq[$];

  task automatic chk(input string name, input int act, input int exp);
    n++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_out(input string tag, input int em, input int ei, input int ec);
    chk({tag, "_max"}, $signed(out_max), em);
    chk({tag, "_idx"}, int'(out_idx), ei);
    chk({tag, "_cnt"}, int'(out_count), ec);
  endtask

  task automatic step(input logic v, input logic l, input int d, input logic ordy);
    in_valid = v;
    in_last = l;
    in_data = WIDTH'(d);
    out_ready = ordy;
    @(negedge clk);
  endtask

  int win[$];
  int mmax, midx, mcnt;
  logic mv, exp_rdy, acc;

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_ready", int'(in_ready), 1);
    chk_out("rst", 0, 0, 0);

    // test 1
    vq.push_back('{1, 0, 3, 0, 0, 0, 0});
    vq.push_back('{1, 0, -7, 0, 0, 0, 0});
    vq.push_back('{1, 0, 9, 0, 0, 0, 0});
    vq.push_back('{1, 0, 9, 1, 9, 2, 4});
    vq.push_back('{0, 0, 0, 0, 0, 0, 0});
    // test 2
    for (int i = 0; i < 3; i++) vq.push_back('{1, 0, -128, 0, 0, 0, 0});
    vq.push_back('{1, 0, -128, 1, -128, 0, 4});
    vq.push_back('{1, 0, 127, 0, 0, 0, 0});
    vq.push_back('{1, 0, -1, 0, 0, 0, 0});
    vq.push_back('{1, 0, 0, 0, 0, 0, 0});
    vq.push_back('{1, 0, 126, 1, 127, 0, 4});
    // test 3: early close then a fresh full window
    vq.push_back('{1, 0, 5, 0, 0, 0, 0});
    vq.push_back('{1, 1, 6, 1, 6, 1, 2});
    vq.push_back('{1, 0, -3, 0, 0, 0, 0});
    vq.push_back('{1, 0, -2, 0, 0, 0, 0});
    vq.push_back('{1, 0, -9, 0, 0, 0, 0});
    vq.push_back('{1, 0, -4, 1, -2, 1, 4});
    // one-sample window and a window spanning idle cycles
    vq.push_back('{1, 1, 77, 1, 77, 0, 1});
    vq.push_back('{1, 0, 5, 0, 0, 0, 0});
    vq.push_back('{0, 1, 99, 0, 0, 0, 0});
    vq.push_back('{0, 0, 99, 0, 0, 0, 0});
    vq.push_back('{1, 0, 2, 0, 0, 0, 0});
    vq.push_back('{1, 1, 8, 1, 8, 2, 3});
    // test 5: back-to-back windows
    for (int i = 1; i <= 12; i++)
      vq.push_back('{1, 0, i, (i % 4) == 0, i, 3, 4});
    vq.push_back('{0, 0, 0, 0, 0, 0, 0});
    foreach (vq[i]) begin
      step(vq[i].v, vq[i].l, vq[i].d, 1'b1);
      chk($sformatf("vec%0d_ready", i), int'(in_ready), 1);
      chk($sformatf("vec%0d_valid", i), int'(out_valid), int'(vq[i].ev));
      if (vq[i].ev) chk_out($sformatf("vec%0d", i), vq[i].em, vq[i].ei, vq[i].ec);
    end

    // test 4: backpressure
    for (int i = 1; i <= 4; i++) step(1'b1, 1'b0, i, 1'b0);
    chk("bp_valid", int'(out_valid), 1);
    chk_out("bp", 4, 3, 4);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, 50, 1'b0);
      chk("bp_hold_ready", int'(in_ready), 0);
      chk("bp_hold_valid", int'(out_valid), 1);
      chk_out("bp_hold", 4, 3, 4);
    end
    step(1'b1, 1'b1, 50, 1'b1);
    chk("bp_release_valid", int'(out_valid), 1);
    chk_out("bp_release", 50, 0, 1);
    step(1'b0, 1'b0, 0, 1'b1);
    chk("bp_nodup_valid", int'(out_valid), 0);

    // test 6: mid-window reset discards partial window
    step(1'b1, 1'b0, 10, 1'b1);
    step(1'b1, 1'b0, 20, 1'b1);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst2_valid", int'(out_valid), 0);
    chk("rst2_ready", int'(in_ready), 1);
    chk_out("rst2", 0, 0, 0);
    for (int i = 1; i <= 4; i++) step(1'b1, 1'b0, i, 1'b1);
    chk("rst2_win_valid", int'(out_valid), 1);
    chk_out("rst2_win", 4, 3, 4);
    step(1'b0, 1'b0, 0, 1'b1);

    // randomized run against a window-list model
    mv = 1'b0;
    mmax = 0; midx = 0; mcnt = 0;
    for (int c = 0; c < 600; c++) begin
      in_valid = $urandom_range(0, 3) != 0;
      in_last = $urandom_range(0, 5) == 0;
      case ($urandom_range(0, 2))
        0: in_data = WIDTH'($urandom_range(0, 2) == 0 ? -128 : $urandom_range(0, 1) ? 127 : 0);
        1: in_data = WIDTH'(int'($urandom_range(0, 6)) - 3);
        default: in_data = WIDTH'($urandom);
      endcase
      out_ready = $urandom_range(0, 3) != 0;
      #1;
      exp_rdy = !mv || out_ready;
      chk("rnd_ready", int'(in_ready), int'(exp_rdy));
      chk("rnd_valid", int'(out_valid), int'(mv));
      if (mv) chk_out("rnd", mmax, midx, mcnt);
      acc = in_valid && exp_rdy;
      if (mv && out_ready) mv = 1'b0;
      if (acc) begin
        win.push_back(int'($signed(in_data)));
        if (win.size() == WINDOW || in_last) begin
          mmax = win[0];
          midx = 0;
          for (int i = 1; i < win.size(); i++)
            if (win[i] > mmax) begin
              mmax = win[i];
              midx = i;
            end
          mcnt = win.size();
          mv = 1'b1;
          win.delete();
        end
      end
      @(negedge clk);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n, errs);
    $finish;
  end
endmodule
